eth_tx_arbiter: RTL and testbench



---
 rtl/eth_pkg.sv | 15 +
 rtl/eth_rr_pick.sv | 41 ++++
 rtl/eth_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared state encoding and frame constants for the Ethernet transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PRE,
        STREAM,
        HOLD
    } tx_state_e;

    localparam int unsigned ETH_MAX_FRAME  = 1514;
    localparam int unsigned ETH_TX_HOLDOFF = 18;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin search: first requester strictly after `last`, wrapping.
module eth_rr_pick #(
    parameter int unsigned NPORTS = 4
) (
    input  logic [NPORTS-1:0] req,
    input  logic [2:0]        last,
    output logic [NPORTS-1:0] gnt,
    output logic [2:0]        idx,
    output logic              any
);

    logic       hi_any;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (req[i]) begin
                if (!any) begin
                    any    = 1'b1;
                    lo_idx = 3'(i);
                end
                if (!hi_any && (3'(i) > last)) begin
                    hi_any = 1'b1;
                    hi_idx = 3'(i);
                end
            end
        end
        idx = hi_any ? hi_idx : lo_idx;
        gnt = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            gnt[i] = any && (3'(i) == idx);
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin packet arbiter in front of a single RGMII transmit engine,
// with start timeout, oversize kill and post-packet holdoff.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int unsigned NPORTS        = 4,
    parameter int unsigned HOLDOFF       = ETH_TX_HOLDOFF,
    parameter int unsigned MAX_BYTES     = ETH_MAX_FRAME,
    parameter int unsigned START_TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORTS-1:0]     src_req,
    input  logic [NPORTS-1:0]     src_valid,
    input  logic [NPORTS-1:0]     src_error,
    input  logic [NPORTS*8-1:0]   src_data,
    output logic [NPORTS-1:0]     src_ready,
    output logic [NPORTS-1:0]     grant,
    output logic                  eng_start,
    output logic                  eng_valid,
    output logic                  eng_error,
    output logic [7:0]            eng_data,
    input  logic                  eng_ready,
    output logic                  abort,
    output logic [2:0]            abort_port
);

    tx_state_e           state_q;
    logic [NPORTS-1:0]   grant_q;
    logic [2:0]          gidx_q;
    logic [2:0]          ptr_q;
    logic [10:0]         cnt_q;
    logic [4:0]          hold_q;
    logic [4:0]          tmo_q;
    logic [4:0]          tmo_d;
    logic                start_q;
    logic                abort_q;
    logic [2:0]          abort_port_q;

    logic [NPORTS-1:0]   pick_gnt;
    logic [2:0]          pick_idx;
    logic                pick_any;

    logic                sel_valid;
    logic                sel_error;
    logic [7:0]          sel_data;
    logic                in_pkt;
    logic                at_max;
    logic                kill;
    logic                accept;

    eth_rr_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .req  (src_req),
        .last (ptr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_error = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) begin
                sel_valid = src_valid[i];
                sel_error = src_error[i];
                sel_data  = src_data[8*i +: 8];
            end
        end
    end

    assign in_pkt = (state_q == PRE) || (state_q == STREAM);
    assign at_max = (cnt_q == 11'(MAX_BYTES));
    assign kill   = in_pkt && (sel_error || (eng_ready && sel_valid && at_max));
    assign accept = in_pkt && eng_ready && sel_valid && !kill;
    assign tmo_d  = tmo_q + 5'd1;

    // src_ready marks bytes the engine actually takes, so kill and end cycles never show it.
    assign src_ready  = accept ? grant_q : '0;
    assign grant      = grant_q;
    assign eng_start  = start_q;
    assign eng_valid  = sel_valid && !kill;
    assign eng_error  = kill;
    assign eng_data   = sel_data;
    assign abort      = abort_q;
    assign abort_port = abort_port_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HOLD;
            grant_q      <= '0;
            gidx_q       <= '0;
            ptr_q        <= 3'(NPORTS - 1);
            cnt_q        <= '0;
            hold_q       <= 5'(HOLDOFF);
            tmo_q        <= '0;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
            abort_port_q <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                        ptr_q   <= pick_idx;
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    tmo_q   <= '0;
                    state_q <= PRE;
                end
                PRE, STREAM: begin
                    if (kill) begin
                        abort_q      <= 1'b1;
                        abort_port_q <= gidx_q;
                        grant_q      <= '0;
                        hold_q       <= 5'(HOLDOFF);
                        state_q      <= HOLD;
                    end else if (eng_ready) begin
                        if (sel_valid) begin
                            cnt_q   <= cnt_q + 11'd1;
                            state_q <= STREAM;
                        end else begin
                            grant_q <= '0;
                            hold_q  <= 5'(HOLDOFF);
                            state_q <= HOLD;
                        end
                    end else if (state_q == PRE) begin
                        tmo_q <= tmo_d;
                        if (tmo_d == 5'(START_TIMEOUT)) begin
                            abort_q      <= 1'b1;
                            abort_port_q <= gidx_q;
                            grant_q      <= '0;
                            hold_q       <= 5'(HOLDOFF);
                            state_q      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    grant_q <= '0;
                    hold_q  <= hold_q - 5'd1;
                    if (hold_q <= 5'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    hold_q  <= 5'(HOLDOFF);
                    state_q <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: round-robin table plus hand-timed packet sequences.
module tb_eth_tx_arbiter;

    localparam int unsigned NP = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   src_req, src_valid, src_error, src_ready, grant;
    logic [NP*8-1:0] src_data;
    logic            eng_start, eng_valid, eng_error, eng_ready, abort;
    logic [7:0]      eng_data;
    logic [2:0]      abort_port;

    int total = 0;
    int bad   = 0;
    int cyc;
    int rem[NP];
    int sent[NP];
    int acc[NP];
    int err_at[NP];
    bit cont_mode;
    bit drop_losers;
    logic [NP-1:0] cont_mask;
    int cont_len;
    int start_cyc[$];
    logic [NP-1:0] start_gnt[$];
    int abort_cyc, kill_cyc, kill_acc;
    logic [2:0] abort_port_seen;

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] gnt;
    } rr_vec_t;
    rr_vec_t vecs[8];

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .NPORTS        (NP),
        .HOLDOFF       (18),
        .MAX_BYTES     (1514),
        .START_TIMEOUT (31)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_req    (src_req),
        .src_valid  (src_valid),
        .src_error  (src_error),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .grant      (grant),
        .eng_start  (eng_start),
        .eng_valid  (eng_valid),
        .eng_error  (eng_error),
        .eng_data   (eng_data),
        .eng_ready  (eng_ready),
        .abort      (abort),
        .abort_port (abort_port)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int unsigned p = 0; p < NP; p++) begin
            if (cont_mode && cont_mask[p] && rem[p] == 0 && !grant[p]) rem[p] = cont_len;
            src_req[p]         = rem[p] > 0;
            src_valid[p]       = rem[p] > 0;
            src_data[8*p +: 8] = 8'(sent[p] + 16 * p);
            src_error[p]       = (err_at[p] >= 0) && (sent[p] == err_at[p]) && (rem[p] > 0);
        end
    endtask

    task automatic observe();
        for (int unsigned p = 0; p < NP; p++) begin
            if (src_ready[p]) begin
                chk("ready_owner", 32'(grant[p]), 1);
                chk("eng_data", 32'(eng_data), 32'(8'(sent[p] + 16 * p)));
                chk("eng_valid", 32'(eng_valid), 1);
                sent[p]++;
                acc[p]++;
                if (rem[p] > 0) rem[p]--;
            end
        end
        if (eng_start) begin
            start_cyc.push_back(cyc);
            start_gnt.push_back(grant);
            if (drop_losers)
                for (int unsigned p = 0; p < NP; p++) if (!grant[p]) rem[p] = 0;
        end
        if (eng_error) begin
            chk("kill_valid_low", 32'(eng_valid), 0);
            kill_cyc = cyc;
            for (int unsigned p = 0; p < NP; p++) if (grant[p]) kill_acc = acc[p];
        end
        if (abort) begin
            abort_cyc       = cyc;
            abort_port_seen = abort_port;
            if (int'(abort_port) < NP) rem[abort_port] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
        cyc++;
        drive();
        #1;
        observe();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_abort", 32'(abort), 0);
        chk("rst_abort_port", 32'(abort_port), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_eng_valid", 32'(eng_valid), 0);
        chk("rst_eng_error", 32'(eng_error), 0);
        chk("rst_eng_data", 32'(eng_data), 0);
        for (int unsigned p = 0; p < NP; p++) begin
            rem[p] = 0; sent[p] = 0; acc[p] = 0; err_at[p] = -1;
        end
        cont_mode = 1'b0; drop_losers = 1'b0; cont_mask = '0; cont_len = 0;
        eng_ready = 1'b1;
        drive();
        start_cyc.delete();
        start_gnt.delete();
        abort_cyc = -1; kill_cyc = -1; kill_acc = -1; abort_port_seen = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic expect_first_start(input string name, input logic [NP-1:0] g);
        for (int n = 0; n < 40 && start_cyc.size() == 0; n++) cycle();
        chk({name, "_seen"}, 32'(start_cyc.size()), 1);
        if (start_cyc.size() > 0) begin
            chk({name, "_cyc"}, 32'(start_cyc[0]), 19);
            chk({name, "_grant"}, 32'(start_gnt[0]), 32'(g));
        end
    endtask

    task automatic wait_starts(input string name, input int n, input int bound);
        for (int i = 0; i < bound && start_cyc.size() < n; i++) cycle();
        chk(name, 32'(start_cyc.size()), 32'(n));
    endtask

    task automatic wait_grant_zero(input string name, input int bound);
        for (int i = 0; i < bound && grant != '0; i++) cycle();
        chk(name, 32'(grant), 0);
    endtask

    task automatic wait_abort(input string name, input int bound);
        for (int i = 0; i < bound && abort_cyc < 0; i++) cycle();
        chk(name, 32'(abort_cyc >= 0), 1);
    endtask

    initial begin
        vecs[0] = '{4'b0110, 4'b0010};
        vecs[1] = '{4'b0011, 4'b0001};
        vecs[2] = '{4'b1111, 4'b0010};
        vecs[3] = '{4'b1000, 4'b1000};
        vecs[4] = '{4'b1000, 4'b1000};
        vecs[5] = '{4'b0101, 4'b0001};
        vecs[6] = '{4'b0101, 4'b0100};
        vecs[7] = '{4'b1111, 4'b1000};

        // single 60-byte packet on port 1, then holdoff to the next start
        do_reset();
        rem[1] = 60;
        expect_first_start("t1_start", 4'b0010);
        wait_grant_zero("t1_release", 200);
        chk("t1_release_cyc", 32'(cyc), 81);
        chk("t1_bytes", 32'(acc[1]), 60);
        rem[1] = 10;
        wait_starts("t1_second", 2, 100);
        if (start_cyc.size() > 1) chk("t1_second_cyc", 32'(start_cyc[1]), 100);
        wait_grant_zero("t1_release2", 60);
        chk("t1_bytes2", 32'(acc[1]), 70);
        chk("t1_no_abort", 32'(abort_cyc), 32'(-1));

        // round-robin table, 3-byte packets
        do_reset();
        drop_losers = 1'b1;
        for (int unsigned v = 0; v < 8; v++) begin
            for (int unsigned p = 0; p < NP; p++) if (vecs[v].req[p]) rem[p] = 3;
            wait_starts("rr_start", int'(v) + 1, 80);
            if (start_cyc.size() > int'(v)) chk("rr_grant", 32'(start_gnt[v]), 32'(vecs[v].gnt));
            wait_grant_zero("rr_release", 40);
        end
        chk("rr_bytes", 32'(acc[0] + acc[1] + acc[2] + acc[3]), 24);

        // ports 0,2,3 requesting continuously with 20-byte packets
        do_reset();
        cont_mode = 1'b1; cont_mask = 4'b1101; cont_len = 20;
        wait_starts("cont_starts", 4, 300);
        if (start_cyc.size() >= 4) begin
            chk("cont_g0", 32'(start_gnt[0]), 32'(4'b0001));
            chk("cont_g1", 32'(start_gnt[1]), 32'(4'b0100));
            chk("cont_g2", 32'(start_gnt[2]), 32'(4'b1000));
            chk("cont_g3", 32'(start_gnt[3]), 32'(4'b0001));
            for (int i = 1; i < 4; i++) chk("cont_gap", 32'(start_cyc[i] - start_cyc[i-1]), 41);
        end

        // port 2 aborts after 10 bytes
        do_reset();
        rem[2] = 30; err_at[2] = 10;
        expect_first_start("err_start", 4'b0100);
        wait_abort("err_abort_seen", 100);
        chk("err_kill_cyc", 32'(kill_cyc), 30);
        chk("err_kill_bytes", 32'(kill_acc), 10);
        chk("err_abort_cyc", 32'(abort_cyc), 31);
        chk("err_abort_port", 32'(abort_port_seen), 2);
        chk("err_hold_grant", 32'(grant), 0);
        err_at[2] = -1; rem[2] = 4;
        wait_starts("err_restart", 2, 60);
        if (start_cyc.size() > 1) chk("err_restart_cyc", 32'(start_cyc[1]), 50);

        // port 0 offers 1600 bytes
        do_reset();
        rem[0] = 1600;
        expect_first_start("big_start", 4'b0001);
        wait_abort("big_abort_seen", 2000);
        chk("big_bytes", 32'(acc[0]), 1514);
        chk("big_kill_bytes", 32'(kill_acc), 1514);
        chk("big_kill_cyc", 32'(kill_cyc), 1534);
        chk("big_abort_cyc", 32'(abort_cyc), 1535);
        chk("big_abort_port", 32'(abort_port_seen), 0);

        // engine never ready after start on port 3
        do_reset();
        eng_ready = 1'b0;
        rem[3] = 5;
        expect_first_start("tmo_start", 4'b1000);
        wait_abort("tmo_abort_seen", 100);
        chk("tmo_abort_cyc", 32'(abort_cyc), 51);
        chk("tmo_abort_port", 32'(abort_port_seen), 3);
        chk("tmo_no_ready", 32'(acc[3]), 0);
        eng_ready = 1'b1;
        rem[3] = 5;
        wait_starts("tmo_restart", 2, 60);
        if (start_cyc.size() > 1) chk("tmo_restart_cyc", 32'(start_cyc[1]), 70);
        wait_grant_zero("tmo_release", 40);
        chk("tmo_bytes", 32'(acc[3]), 5);

        // reset asserted mid-stream, then everyone requests
        do_reset();
        rem[1] = 100;
        expect_first_start("mid_start", 4'b0010);
        for (int i = 0; i < 200 && acc[1] < 20; i++) cycle();
        chk("mid_bytes", 32'(acc[1]), 20);
        do_reset();
        for (int unsigned p = 0; p < NP; p++) rem[p] = 5;
        expect_first_start("post_rst_start", 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
